// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for the RV32M multiply group (MUL/MULH/MULHSU/MULHU).
// Multiplies operand magnitudes, then applies a final two's-complement sign fix.
module mul_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             kill,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [PW-1:0]    prod;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic             neg;
   logic [1:0]       op_q;

   logic             a_sgn;
   logic             b_sgn;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   sum;
   logic [PW-1:0]    prod_fix;
   logic             last;
   logic             accept;

   // Operand magnitudes, partial-sum adder and final sign correction
   always_comb begin
      a_sgn    = ((op == 2'b01) || (op == 2'b10)) && a[WIDTH-1];
      b_sgn    = (op == 2'b01) && b[WIDTH-1];
      a_mag    = a_sgn ? (~a + WIDTH'(1)) : a;
      b_mag    = b_sgn ? (~b + WIDTH'(1)) : b;
      sum      = {1'b0, prod[PW-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      prod_fix = neg ? (~prod + PW'(1)) : prod;
      last     = (cnt == CNT_W'(WIDTH - 1));
      accept   = start && !kill;
   end

   // State register; busy/done registered from the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != S_IDLE);
         done  <= (state_nxt == S_DONE);
      end
   end

   // Next-state logic; kill wins over any advance
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (accept) state_nxt = S_CALC;
         S_CALC:  if (kill) state_nxt = S_IDLE;
                  else if (last) state_nxt = S_FIX;
         S_FIX:   state_nxt = kill ? S_IDLE : S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: load magnitudes, shift-add iterations, sign fix and word select
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         op_q   <= 2'b00;
         result <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q   <= op;
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= a_sgn ^ b_sgn;
                  prod   <= '0;
                  cnt    <= '0;
               end
            end
            S_CALC: begin
               if (!kill) begin
                  prod   <= {sum, prod[WIDTH-1:1]};
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CNT_W'(1);
               end
            end
            S_FIX: begin
               if (!kill) begin
                  prod   <= prod_fix;
                  result <= (op_q == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[PW-1:WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases, kill/reset/ignored-start
// scenarios and random operands against a 64-bit arithmetic reference.
module tb_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        kill;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] last_exp = 32'h0;

   always #5 clk = ~clk;

   mul_seq #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .kill   (kill),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   // Reference: extend each operand per its signedness, multiply mod 2^64, pick a word
   function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] ex;
      logic [63:0] ey;
      logic [63:0] p;
      ex = ((o == 2'b01) || (o == 2'b10)) ? {{32{x[31]}}, x} : {32'h0, x};
      ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'h0, y};
      p  = ex * ey;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One job: start in cycle 0, optional stray start pulse at cycle ign, expect done at cycle 34
   task automatic mul_job(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit chk_busy, input int ign);
      int cyc;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1; kill = 1'b0;
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         if (chk_busy && cyc <= 33) check({tag, " busy"}, 64'(busy), 64'(1));
         start = (cyc == ign);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      last_exp = ref_mul(o, x, y);
      check({tag, " latency"}, 64'(cyc), 64'(34));
      check({tag, " result"}, 64'(result), 64'(last_exp));
   endtask

   task automatic watch_no_done(input string tag, input int n);
      bit seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check({tag, " no done"}, 64'(seen), 64'(0));
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset result", 64'(result), 64'(0));
      rst_n = 1'b1;

      mul_job("mul 7x6", 2'b00, 32'd7, 32'd6, 1'b1, 0);
      check("mul 7x6 const", 64'(result), 64'h2A);
      mul_job("mulh min*min", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
      check("mulh min*min const", 64'(result), 64'h4000_0000);
      mul_job("mul min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
      mul_job("mulhu -1*-1", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      check("mulhu -1*-1 const", 64'(result), 64'hFFFF_FFFE);
      mul_job("mulh -1*-1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      mul_job("mulhsu -1*max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      check("mulhsu -1*max const", 64'(result), 64'hFFFF_FFFF);
      mul_job("mul min*-1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      check("mul min*-1 const", 64'(result), 64'h8000_0000);
      mul_job("mulh zero", 2'b01, 32'h0, 32'h8000_0000, 1'b0, 0);
      mul_job("mulhsu neg*3", 2'b10, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);

      // Kill in cycle 10: no done, idle from cycle 11, result held
      @(negedge clk);
      op = 2'b00; a = 32'd5; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill busy", 64'(busy), 64'(0));
      watch_no_done("kill", 40);
      check("kill result held", 64'(result), 64'(last_exp));

      // Stray start at cycle 5 is ignored and not queued
      mul_job("ignored start", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5);
      watch_no_done("ignored start", 40);

      // Reset for one edge in cycle 20
      @(negedge clk);
      op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst busy", 64'(busy), 64'(0));
      check("midrst done", 64'(done), 64'(0));
      check("midrst result", 64'(result), 64'(0));
      mul_job("after rst", 2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 0);

      // Random back-to-back jobs
      for (int i = 0; i < 20; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 1) ra = 32'h8000_0000;
         if (i % 7 == 2) rb = 32'hFFFF_FFFF;
         mul_job($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
